tlb_assoc: RTL and testbench
============================

# tlb_assoc

Parametrised set-associative translation lookaside buffer with registered lookup, miss handshake toward a page-walk/refill agent, per-set round-robin replacement and a multi-cycle flush. It sits between the core's address generation and the cache/memory request path. It supersedes the direct-mapped, 4-line TLB with configurable sets, ways, address width and page size, and adds fault reporting.

## Interface
- ARCH_BITS, 32, virtual/physical address width
- PAGE_BITS, 12, page-offset width (page size 2^PAGE_BITS)
- SETS, 4, number of sets (power of two, ≥2)
- WAYS, 2, associativity (≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  translation enable, sampled at request acceptance; 0 = identity mapping
- req_valid  in  1  lookup request
- req_vaddr  in  ARCH_BITS  virtual address
- req_ready  out  1  block can accept a request this cycle
- resp_valid  out  1  one-cycle pulse, response valid
- resp_paddr  out  ARCH_BITS  translated address
- resp_fault  out  1  translation fault (refill reported fault)
- miss_valid  out  1  refill request, held until fill_valid
- miss_vpn  out  ARCH_BITS-PAGE_BITS  virtual page number to walk
- fill_valid  in  1  refill response (honoured only while miss_valid=1)
- fill_ppn  in  ARCH_BITS-PAGE_BITS  physical page number
- fill_fault  in  1  walk failed; entry is not installed
- flush  in  1  invalidate all entries (level, sampled in IDLE)
- flush_done  out  1  one-cycle pulse when flush completes

## Operation
- Address split: VPN = vaddr[ARCH_BITS-1:PAGE_BITS]; index = low log2(SETS) bits of VPN; tag = remaining VPN bits.
- Entry: valid, tag, PPN. Per set: round-robin victim pointer, log2(WAYS) bits (0 bits if WAYS=1).
- States: IDLE, MISS, FLUSH.
- IDLE: req_ready=1 unless flush=1. flush has priority: go to FLUSH, set counter=0.
- Accept (req_valid&&req_ready) with enable=0: next cycle resp_valid=1, resp_paddr=req_vaddr, resp_fault=0. The TLB is not accessed.
- Accept with enable=1: compare tag across all ways of the indexed set.
  - Hit: next cycle resp_valid=1, resp_paddr={PPN, vaddr offset}, resp_fault=0. Remain in IDLE.
  - Miss: go to MISS; capture the vaddr; miss_valid=1 and miss_vpn=VPN from the next cycle.
- MISS: req_ready=0. On fill_valid:
  - fill_fault=0: install {tag, fill_ppn} into the victim way. Response {fill_ppn, offset}, fault=0.
  - fill_fault=1: no install. Response paddr=0, fault=1.
  - In both cases resp_valid is asserted the next cycle, miss_valid drops the next cycle, and the block returns to IDLE.
- Victim selection: lowest-index invalid way. If all ways are valid, use the set pointer, then increment it mod WAYS. The pointer is unchanged when an invalid way is used.
- FLUSH: clear the valid bits of set[counter] each cycle; counter increments. After set SETS-1 is cleared, flush_done pulses the next cycle and the block returns to IDLE. Pointers are reset to 0. req_ready=0 throughout.
- flush asserted during MISS: held pending; the flush starts in the cycle after the miss response, before any new request.
- fill_valid outside MISS: ignored.

## Timing
- Reset: all valid bits=0, pointers=0, state=IDLE. Outputs resp_valid, resp_fault, miss_valid, flush_done = 0; resp_paddr, miss_vpn = 0; req_ready=0 while rst=1, and 1 from the first cycle after.
- Hit/identity latency: 1 cycle. Back-to-back hits give 1 response per cycle, because req_ready stays high in the cycle resp_valid pulses.
- Miss latency: 1 cycle to miss_valid, plus walk time, plus 1 cycle from fill_valid to resp_valid.
- Flush: SETS cycles of clearing plus 1 cycle for flush_done.
- A fill written in cycle N is visible to a lookup accepted in cycle N+1.
- rst mid-miss or mid-flush: abandon the operation. No resp_valid or flush_done is produced, and miss_valid is 0 in the next cycle.

## Test plan
- Reset then enable=0, req 0x1234_5678: resp_valid 1 cycle later, paddr 0x1234_5678, fault 0, miss_valid never high.
- enable=1, cold req 0x0000_3ABC: miss_valid with miss_vpn 0x00003. Fill ppn 0x00080 → resp 0x0008_0ABC. A repeat req hits in 1 cycle with no miss.
- SETS=4, WAYS=2: fill VPNs 0x00001, 0x00005, 0x00009 (all index 1). The third fill evicts way 0 (VPN 0x00001). A req for 0x00001 misses again; 0x00005 still hits.
- Fill with fill_fault=1 for VPN 0x00007: resp fault=1, paddr 0. A repeat request misses again (not installed).
- Flush in IDLE with 2 valid entries: req_ready low for 4 cycles, flush_done on cycle 5. Prior hits now miss. Flush raised during MISS runs after the miss response.
- rst asserted while miss_valid=1: miss_valid=0 next cycle, no resp_valid, all entries invalid afterwards.

Source files
------------

// File: rtl/tlb_assoc.sv
// tlb_assoc: set-associative TLB with a registered lookup, a miss handshake
// toward a page-walk agent, per-set round-robin replacement and a flush that
// clears one set per cycle. With enable low the block is an identity map.

module tlb_assoc #(
  parameter int ARCH_BITS = 32,
  parameter int PAGE_BITS = 12,
  parameter int SETS      = 4,
  parameter int WAYS      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           req_valid,
  input  logic [ARCH_BITS-1:0]           req_vaddr,
  output logic                           req_ready,
  output logic                           resp_valid,
  output logic [ARCH_BITS-1:0]           resp_paddr,
  output logic                           resp_fault,
  output logic                           miss_valid,
  output logic [ARCH_BITS-PAGE_BITS-1:0] miss_vpn,
  input  logic                           fill_valid,
  input  logic [ARCH_BITS-PAGE_BITS-1:0] fill_ppn,
  input  logic                           fill_fault,
  input  logic                           flush,
  output logic                           flush_done
);

  localparam int VPN_BITS = ARCH_BITS - PAGE_BITS;
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = VPN_BITS - IDX_BITS;
  // A single-way TLB still carries a one-bit pointer that never moves.
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    FLUSH
  } state_t;

  state_t                 state;
  logic [IDX_BITS-1:0]    flush_cnt;
  logic                   flush_pend;
  logic [ARCH_BITS-1:0]   miss_vaddr;

  logic [WAYS-1:0]        valid_bits [SETS];
  logic [WAY_BITS-1:0]    rr_ptr     [SETS];
  logic [TAG_BITS-1:0]    tag_mem    [SETS][WAYS];
  logic [VPN_BITS-1:0]    ppn_mem    [SETS][WAYS];

  logic [VPN_BITS-1:0]    req_vpn;
  logic [IDX_BITS-1:0]    req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic [PAGE_BITS-1:0]   req_off;

  logic [VPN_BITS-1:0]    walk_vpn;
  logic [IDX_BITS-1:0]    walk_idx;
  logic [TAG_BITS-1:0]    walk_tag;
  logic [PAGE_BITS-1:0]   walk_off;

  logic                   hit;
  logic [VPN_BITS-1:0]    hit_ppn;
  logic [WAY_BITS-1:0]    victim;
  logic                   victim_from_ptr;
  logic [WAY_BITS-1:0]    ptr_next;

  logic                   flush_req;
  logic                   accept;
  logic                   install;
  logic                   flush_last;

  assign req_vpn  = req_vaddr[ARCH_BITS-1:PAGE_BITS];
  assign req_idx  = req_vpn[IDX_BITS-1:0];
  assign req_tag  = req_vpn[VPN_BITS-1:IDX_BITS];
  assign req_off  = req_vaddr[PAGE_BITS-1:0];

  assign walk_vpn = miss_vaddr[ARCH_BITS-1:PAGE_BITS];
  assign walk_idx = walk_vpn[IDX_BITS-1:0];
  assign walk_tag = walk_vpn[VPN_BITS-1:IDX_BITS];
  assign walk_off = miss_vaddr[PAGE_BITS-1:0];

  // A flush seen during a miss is remembered, so it wins over new requests too.
  assign flush_req  = flush || flush_pend;
  assign req_ready  = !rst && (state == IDLE) && !flush_req;
  assign accept     = req_valid && req_ready;
  assign install    = (state == MISS) && fill_valid && !fill_fault;
  assign flush_last = (flush_cnt == IDX_BITS'(SETS - 1));

  // Compare the request tag against every way of its set in parallel.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_bits[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_ppn = ppn_mem[req_idx][w];
      end
    end
  end

  // Pick the lowest free way of the walked set, else the round-robin pointer.
  always_comb begin
    victim          = rr_ptr[walk_idx];
    victim_from_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_bits[walk_idx][w]) begin
        victim          = WAY_BITS'(w);
        victim_from_ptr = 1'b0;
      end
    end
    if (rr_ptr[walk_idx] == WAY_BITS'(WAYS - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = rr_ptr[walk_idx] + WAY_BITS'(1);
    end
  end

  // Controller: request acceptance, the miss handshake and the flush sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
      miss_vaddr <= '0;
      resp_valid <= 1'b0;
      resp_paddr <= '0;
      resp_fault <= 1'b0;
      miss_valid <= 1'b0;
      miss_vpn   <= '0;
      flush_done <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state      <= FLUSH;
            flush_cnt  <= '0;
            flush_pend <= 1'b0;
          end else if (accept) begin
            if (!enable) begin
              resp_valid <= 1'b1;
              resp_paddr <= req_vaddr;
              resp_fault <= 1'b0;
            end else if (hit) begin
              resp_valid <= 1'b1;
              resp_paddr <= {hit_ppn, req_off};
              resp_fault <= 1'b0;
            end else begin
              state      <= MISS;
              miss_vaddr <= req_vaddr;
              miss_valid <= 1'b1;
              miss_vpn   <= req_vpn;
            end
          end
        end
        MISS: begin
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (fill_valid) begin
            state      <= IDLE;
            miss_valid <= 1'b0;
            resp_valid <= 1'b1;
            if (fill_fault) begin
              resp_paddr <= '0;
              resp_fault <= 1'b1;
            end else begin
              resp_paddr <= {fill_ppn, walk_off};
              resp_fault <= 1'b0;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + IDX_BITS'(1);
          if (flush_last) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Valid bits and replacement pointers: cleared by reset or the flush sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_bits[s] <= '0;
        rr_ptr[s]     <= '0;
      end
    end else if (state == FLUSH) begin
      valid_bits[flush_cnt] <= '0;
      rr_ptr[flush_cnt]     <= '0;
    end else if (install) begin
      valid_bits[walk_idx][victim] <= 1'b1;
      if (victim_from_ptr) begin
        rr_ptr[walk_idx] <= ptr_next;
      end
    end
  end

  // Tag and PPN storage needs no reset; the valid bits guard every read.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[walk_idx][victim] <= walk_tag;
      ppn_mem[walk_idx][victim] <= fill_ppn;
    end
  end

endmodule

// File: tb/tb_tlb_assoc.sv
// tb_tlb_assoc: randomized and directed bench for tlb_assoc, predicting every
// response from a set/way table model kept in plain arrays.

module tb_tlb_assoc;

  localparam int SETS = 4;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_vaddr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_fault;
  logic        miss_valid;
  logic [19:0] miss_vpn;
  logic        fill_valid = 1'b0;
  logic [19:0] fill_ppn = '0;
  logic        fill_fault = 1'b0;
  logic        flush = 1'b0;
  logic        flush_done;

  int vectors = 0;
  int miscompares = 0;

  // Reference table: which virtual page sits in which way of which set.
  logic        m_valid [SETS][WAYS];
  logic [19:0] m_vpn   [SETS][WAYS];
  logic [19:0] m_ppn   [SETS][WAYS];
  int          m_ptr   [SETS];

  tlb_assoc #(.ARCH_BITS(32), .PAGE_BITS(12), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid),
    .req_vaddr(req_vaddr), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_paddr(resp_paddr), .resp_fault(resp_fault), .miss_valid(miss_valid),
    .miss_vpn(miss_vpn), .fill_valid(fill_valid), .fill_ppn(fill_ppn),
    .fill_fault(fill_fault), .flush(flush), .flush_done(flush_done)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case the design wedges somewhere no bounded wait covers.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_lookup(input logic [19:0] vpn, output logic hit, output logic [19:0] ppn);
    int s;
    s = int'(vpn % SETS);
    hit = 1'b0;
    ppn = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_vpn[s][w] == vpn) begin
        hit = 1'b1;
        ppn = m_ppn[s][w];
      end
  endtask

  task automatic model_install(input logic [19:0] vpn, input logic [19:0] ppn);
    int s, v;
    s = int'(vpn % SETS);
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_vpn[s][v] = vpn;
    m_ppn[s][v] = ppn;
  endtask

  // One full lookup: accept, then either a direct response or a walk and fill.
  task automatic run_request(input logic [31:0] va, input logic en, input logic [19:0] fppn,
                             input logic ffault, input int delay, output logic obs_miss,
                             output logic [31:0] got_paddr, output logic got_fault);
    logic        hit;
    logic [19:0] mppn;
    logic [19:0] vpn;
    logic [31:0] exp_pa;
    vpn = va[31:12];
    hit = 1'b1;
    mppn = '0;
    if (en) model_lookup(vpn, hit, mppn);
    @(negedge clk);
    enable = en;
    req_valid = 1'b1;
    req_vaddr = va;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL req_ready: got %b, expected 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    obs_miss = miss_valid;
    if (hit) begin
      exp_pa = en ? {mppn, va[11:0]} : va;
      vectors++;
      if (resp_valid !== 1'b1 || miss_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL direct_resp va=%h: resp_valid=%b miss_valid=%b, expected 1/0", va, resp_valid, miss_valid);
      end
      vectors++;
      if (resp_paddr !== exp_pa || resp_fault !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL direct_paddr va=%h: got %h/%b, expected %h/0", va, resp_paddr, resp_fault, exp_pa);
      end
    end else begin
      vectors++;
      if (miss_valid !== 1'b1 || miss_vpn !== vpn || resp_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL miss_req va=%h: miss_valid=%b vpn=%h resp_valid=%b, expected 1/%h/0", va, miss_valid, miss_vpn, resp_valid, vpn);
      end
      repeat (delay) begin
        @(negedge clk);
        vectors++;
        if (miss_valid !== 1'b1 || resp_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL miss_hold: miss_valid=%b resp_valid=%b, expected 1/0", miss_valid, resp_valid);
        end
      end
      fill_valid = 1'b1;
      fill_ppn = fppn;
      fill_fault = ffault;
      @(negedge clk);
      fill_valid = 1'b0;
      fill_fault = 1'b0;
      exp_pa = ffault ? 32'h0 : {fppn, va[11:0]};
      if (!ffault) model_install(vpn, fppn);
      vectors++;
      if (resp_valid !== 1'b1 || miss_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fill_resp va=%h: resp_valid=%b miss_valid=%b, expected 1/0", va, resp_valid, miss_valid);
      end
      vectors++;
      if (resp_paddr !== exp_pa || resp_fault !== ffault) begin
        miscompares++;
        $display("[TB] FAIL fill_paddr va=%h: got %h/%b, expected %h/%b", va, resp_paddr, resp_fault, exp_pa, ffault);
      end
    end
    got_paddr = resp_paddr;
    got_fault = resp_fault;
  endtask

  // Flush from IDLE: SETS cycles with req_ready low, then a flush_done pulse.
  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_block: req_ready=%b, expected 0", req_ready); end
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      vectors++;
      if (req_ready !== 1'b0 || flush_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flush_busy cycle %0d: ready=%b done=%b, expected 0/0", i, req_ready, flush_done);
      end
      @(negedge clk);
    end
    vectors++;
    if (flush_done !== 1'b1 || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_done: done=%b ready=%b, expected 1/1", flush_done, req_ready);
    end
    @(negedge clk);
    vectors++;
    if (flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_pulse: done=%b, expected 0", flush_done); end
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || miss_valid !== 1'b0 || flush_done !== 1'b0 ||
        resp_paddr !== 32'h0 || resp_fault !== 1'b0 || miss_vpn !== 20'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: ready=%b rv=%b mv=%b fd=%b pa=%h f=%b vpn=%h, expected all 0",
               req_ready, resp_valid, miss_valid, flush_done, resp_paddr, resp_fault, miss_vpn);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_after_reset: got %b, expected 1", req_ready); end
  endtask

  task automatic test_identity();
    logic m, f;
    logic [31:0] pa;
    run_request(32'h1234_5678, 1'b0, 20'h0, 1'b0, 0, m, pa, f);
    vectors++;
    if (pa !== 32'h1234_5678 || m !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL identity: paddr=%h miss=%b, expected 12345678/0", pa, m);
    end
  endtask

  task automatic test_miss_fill();
    logic m, f;
    logic [31:0] pa;
    run_request(32'h0000_3ABC, 1'b1, 20'h00080, 1'b0, 2, m, pa, f);
    vectors++;
    if (m !== 1'b1 || pa !== 32'h0008_0ABC) begin
      miscompares++;
      $display("[TB] FAIL cold_miss: miss=%b paddr=%h, expected 1/00080abc", m, pa);
    end
    run_request(32'h0000_3ABC, 1'b1, 20'h0, 1'b0, 0, m, pa, f);
    vectors++;
    if (m !== 1'b0 || pa !== 32'h0008_0ABC) begin
      miscompares++;
      $display("[TB] FAIL repeat_hit: miss=%b paddr=%h, expected 0/00080abc", m, pa);
    end
  endtask

  task automatic test_eviction();
    logic m, f;
    logic [31:0] pa;
    test_reset();
    run_request(32'h0000_1000, 1'b1, 20'h00A01, 1'b0, 0, m, pa, f);
    run_request(32'h0000_5000, 1'b1, 20'h00A05, 1'b0, 1, m, pa, f);
    run_request(32'h0000_9000, 1'b1, 20'h00A09, 1'b0, 0, m, pa, f);
    run_request(32'h0000_5444, 1'b1, 20'h0, 1'b0, 0, m, pa, f);
    vectors++;
    if (m !== 1'b0 || pa !== 32'h00A0_5444) begin
      miscompares++;
      $display("[TB] FAIL survivor_hit: miss=%b paddr=%h, expected 0/00a05444", m, pa);
    end
    run_request(32'h0000_1010, 1'b1, 20'h00B01, 1'b0, 0, m, pa, f);
    vectors++;
    if (m !== 1'b1 || pa !== 32'h00B0_1010) begin
      miscompares++;
      $display("[TB] FAIL evicted_miss: miss=%b paddr=%h, expected 1/00b01010", m, pa);
    end
  endtask

  task automatic test_fault();
    logic m, f;
    logic [31:0] pa;
    run_request(32'h0000_7123, 1'b1, 20'h12345, 1'b1, 1, m, pa, f);
    vectors++;
    if (pa !== 32'h0 || f !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fault_resp: paddr=%h fault=%b, expected 0/1", pa, f);
    end
    run_request(32'h0000_7123, 1'b1, 20'h00777, 1'b0, 0, m, pa, f);
    vectors++;
    if (m !== 1'b1 || f !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fault_not_installed: miss=%b fault=%b, expected 1/0", m, f);
    end
  endtask

  task automatic test_flush_idle();
    logic m, f;
    logic [31:0] pa;
    do_flush();
    run_request(32'h0000_9000, 1'b1, 20'h00C09, 1'b0, 0, m, pa, f);
    vectors++;
    if (m !== 1'b1) begin miscompares++; $display("[TB] FAIL flushed_miss: miss=%b, expected 1", m); end
  endtask

  task automatic test_flush_during_miss();
    logic m, f, seen, early;
    logic [31:0] pa;
    run_request(32'h0000_2000, 1'b1, 20'h00D02, 1'b0, 0, m, pa, f);
    @(negedge clk);
    enable = 1'b1;
    req_valid = 1'b1;
    req_vaddr = 32'h0000_6456;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    fill_valid = 1'b1;
    fill_ppn = 20'h00D06;
    @(negedge clk);
    fill_valid = 1'b0;
    vectors++;
    if (resp_valid !== 1'b1 || resp_paddr !== 32'h00D0_6456 || req_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pending_flush_resp: rv=%b pa=%h ready=%b, expected 1/00d06456/0", resp_valid, resp_paddr, req_ready);
    end
    seen = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (flush_done === 1'b1) seen = 1'b1;
      else if (req_ready !== 1'b0) early = 1'b1;
    end
    vectors++;
    if (seen !== 1'b1 || early !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pending_flush_run: done_seen=%b ready_early=%b, expected 1/0", seen, early);
    end
    model_clear();
    run_request(32'h0000_2000, 1'b1, 20'h00E02, 1'b0, 0, m, pa, f);
    vectors++;
    if (m !== 1'b1) begin miscompares++; $display("[TB] FAIL post_flush_miss: miss=%b, expected 1", m); end
  endtask

  task automatic test_back_to_back();
    logic m, f;
    logic [31:0] pa;
    logic [31:0] vas [3];
    logic        ens [3];
    logic [31:0] exp [3];
    logic        hit;
    logic [19:0] ppn;
    run_request(32'h0001_1000, 1'b1, 20'h0F011, 1'b0, 0, m, pa, f);
    run_request(32'h0002_2000, 1'b1, 20'h0F022, 1'b0, 0, m, pa, f);
    vas[0] = 32'h0001_1123; ens[0] = 1'b1;
    vas[1] = 32'h0002_2456; ens[1] = 1'b1;
    vas[2] = 32'hDEAD_BEEF; ens[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      model_lookup(vas[k][31:12], hit, ppn);
      exp[k] = ens[k] ? {ppn, vas[k][11:0]} : vas[k];
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_vaddr = vas[0];
    enable = ens[0];
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b1 || resp_paddr !== exp[k-1] || req_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL back_to_back %0d: rv=%b pa=%h ready=%b, expected 1/%h/1", k - 1, resp_valid, resp_paddr, req_ready, exp[k-1]);
      end
      if (k < 3) begin
        req_vaddr = vas[k];
        enable = ens[k];
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic m, f, bad;
    logic [31:0] pa;
    run_request(32'h0003_3000, 1'b1, 20'h01033, 1'b0, 0, m, pa, f);
    @(negedge clk);
    enable = 1'b1;
    req_valid = 1'b1;
    req_vaddr = 32'h0004_4000;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fill_valid = 1'b1;
    fill_ppn = 20'h01044;
    model_clear();
    vectors++;
    if (miss_valid !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_miss: mv=%b rv=%b, expected 0/0", miss_valid, resp_valid);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      fill_valid = 1'b0;
      if (resp_valid !== 1'b0 || miss_valid !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin miscompares++; $display("[TB] FAIL quiet_after_reset: activity=%b, expected 0", bad); end
    run_request(32'h0003_3000, 1'b1, 20'h01133, 1'b0, 0, m, pa, f);
    vectors++;
    if (m !== 1'b1) begin miscompares++; $display("[TB] FAIL entries_cleared: miss=%b, expected 1", m); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    bad = 1'b0;
    repeat (SETS + 2) begin
      @(negedge clk);
      if (flush_done !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_flush: flush_done or stall seen=%b, expected 0", bad); end
  endtask

  task automatic test_stray_fill();
    @(negedge clk);
    fill_valid = 1'b1;
    fill_ppn = 20'($urandom);
    @(negedge clk);
    fill_valid = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || miss_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stray_fill: rv=%b mv=%b, expected 0/0", resp_valid, miss_valid);
    end
  endtask

  task automatic test_random();
    logic m, f;
    logic [31:0] pa;
    logic [19:0] vpn;
    logic [31:0] va;
    for (int i = 0; i < 300; i++) begin
      vpn = 20'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) vpn = vpn | 20'h80000;
      va = {vpn, 12'($urandom)};
      run_request(va, ($urandom_range(0, 9) != 0), 20'($urandom), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 3)), m, pa, f);
      if ($urandom_range(0, 39) == 0) do_flush();
      if ($urandom_range(0, 19) == 0) test_stray_fill();
    end
  endtask

  // Scenario sequence, then the single summary line.
  initial begin
    model_clear();
    test_reset();
    test_identity();
    test_miss_fill();
    test_eviction();
    test_fault();
    test_flush_idle();
    test_flush_during_miss();
    test_back_to_back();
    test_stray_fill();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
